// File: rtl/mem_bus_arbiter_pkg.sv
`default_nettype none
//////////////////////////////////////////////////////////////////////////////
// mem_bus_arbiter_pkg - shared state encodings and widths for the arbiter
// Rev 1.0 - initial release
//////////////////////////////////////////////////////////////////////////////
package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_BUSY_I = 2'd1,
    ARB_BUSY_D = 2'd2
  } arb_state_t;

  // Wide enough for the largest allowed streak limit (15)
  localparam int STREAK_W = 4;

endpackage
`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
//////////////////////////////////////////////////////////////////////////////
// mem_bus_arbiter - fetch/data arbiter for one single-port variable-latency memory
// Rev 1.0 - initial release
//////////////////////////////////////////////////////////////////////////////
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MAX_D_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  output logic              if_stall,
  input  logic              d_rd,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              d_stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  localparam logic [STREAK_W-1:0] c_max_streak = STREAK_W'(MAX_D_STREAK);

  arb_state_t          r_state;
  logic [STREAK_W-1:0] r_streak;

  logic w_d_pend;
  logic w_grant_d;
  logic w_grant_i;

  // Data wins unless it has already used up its streak while a fetch waits
  always_comb begin
    w_d_pend  = d_rd | d_wr;
    w_grant_d = 1'b0;
    w_grant_i = 1'b0;
    if (r_state == ARB_IDLE) begin
      w_grant_d = w_d_pend && ((r_streak < c_max_streak) || !if_req);
      w_grant_i = !w_grant_d && if_req;
    end
  end

  always_comb begin
    if_ready = (r_state == ARB_BUSY_I) && mem_ready;
    d_ready  = (r_state == ARB_BUSY_D) && mem_ready;
    if_rdata = if_ready ? mem_rdata : '0;
    d_rdata  = d_ready ? mem_rdata : '0;
    if_stall = if_req && !if_ready;
    d_stall  = w_d_pend && !d_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ARB_IDLE;
      r_streak  <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (w_grant_d) begin
            r_state   <= ARB_BUSY_D;
            mem_req   <= 1'b1;
            mem_we    <= d_wr;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            if (!if_req)
              r_streak <= '0;
            else if (r_streak != c_max_streak)
              r_streak <= r_streak + 1'b1;
          end else if (w_grant_i) begin
            r_state  <= ARB_BUSY_I;
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= if_addr;
            r_streak <= '0;
          end
        end
        ARB_BUSY_I, ARB_BUSY_D: begin
          if (mem_ready) begin
            r_state <= ARB_IDLE;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
          end
        end
        default: begin
          r_state <= ARB_IDLE;
          mem_req <= 1'b0;
          mem_we  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
//////////////////////////////////////////////////////////////////////////////
// tb_mem_bus_arbiter - directed self-checking bench for mem_bus_arbiter
// Rev 1.0 - initial release
//////////////////////////////////////////////////////////////////////////////
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        if_stall;
  logic        d_rd;
  logic        d_wr;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ready;
  logic        d_stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  int tests = 0;
  int fails = 0;

  mem_bus_arbiter #(
    .ADDR_W(32),
    .DATA_W(32),
    .MAX_D_STREAK(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .if_req(if_req),
    .if_addr(if_addr),
    .if_rdata(if_rdata),
    .if_ready(if_ready),
    .if_stall(if_stall),
    .d_rd(d_rd),
    .d_wr(d_wr),
    .d_addr(d_addr),
    .d_wdata(d_wdata),
    .d_rdata(d_rdata),
    .d_ready(d_ready),
    .d_stall(d_stall),
    .mem_req(mem_req),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; if_req = 1'b0; if_addr = '0; d_rd = 1'b0; d_wr = 1'b0;
    d_addr = '0; d_wdata = '0; mem_rdata = '0; mem_ready = 1'b0;
    #3;
    tests++;
    if ({mem_req, mem_we, if_ready, d_ready, if_stall, d_stall} !== 6'b0) begin
      fails++;
      $display("FAIL reset_ctrl: got %b expected 000000",
               {mem_req, mem_we, if_ready, d_ready, if_stall, d_stall});
    end
    tests++;
    if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
      fails++;
      $display("FAIL reset_bus: got addr %h wdata %h expected 0 0", mem_addr, mem_wdata);
    end
    next_cycle();
    rst_n = 1'b1;
    d_rd = 1'b1; d_addr = 32'h0000_0010;
    next_cycle();
    tests++;
    if (mem_req !== 1'b1) begin
      fails++;
      $display("FAIL reset_pre_busy: got mem_req %b expected 1", mem_req);
    end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if ({mem_req, d_ready, d_stall, if_ready, if_stall} !== 5'b00100) begin
      fails++;
      $display("FAIL reset_async: got %b expected 00100",
               {mem_req, d_ready, d_stall, if_ready, if_stall});
    end
    d_rd = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    next_cycle();
  endtask

  task automatic test_single_fetch;
    if_req = 1'b1; if_addr = 32'h0000_0040;
    #1;
    tests++;
    if (if_stall !== 1'b1 || mem_req !== 1'b0) begin
      fails++;
      $display("FAIL fetch_c0: got stall %b req %b expected 1 0", if_stall, mem_req);
    end
    for (int c = 1; c <= 2; c++) begin
      next_cycle();
      tests++;
      if ({mem_req, mem_we, if_ready, if_stall} !== 4'b1001 || mem_addr !== 32'h40) begin
        fails++;
        $display("FAIL fetch_c%0d: got req/we/rdy/stall %b addr %h expected 1001 00000040",
                 c, {mem_req, mem_we, if_ready, if_stall}, mem_addr);
      end
    end
    next_cycle();
    mem_ready = 1'b1; mem_rdata = 32'h2002_0005;
    #1;
    tests++;
    if ({mem_req, if_ready, if_stall} !== 3'b110 || if_rdata !== 32'h2002_0005) begin
      fails++;
      $display("FAIL fetch_c3: got req/rdy/stall %b rdata %h expected 110 20020005",
               {mem_req, if_ready, if_stall}, if_rdata);
    end
    next_cycle();
    if_req = 1'b0; mem_ready = 1'b0; mem_rdata = 32'hFFFF_FFFF;
    #1;
    tests++;
    if (mem_req !== 1'b0 || if_ready !== 1'b0 || if_rdata !== 32'h0) begin
      fails++;
      $display("FAIL fetch_c4: got req %b rdy %b rdata %h expected 0 0 0",
               mem_req, if_ready, if_rdata);
    end
    mem_rdata = '0;
  endtask

  task automatic test_store;
    d_wr = 1'b1; d_addr = 32'h0000_0100; d_wdata = 32'hDEAD_BEEF;
    next_cycle();
    tests++;
    if ({mem_req, mem_we, d_ready, d_stall} !== 4'b1101 || mem_addr !== 32'h100
        || mem_wdata !== 32'hDEAD_BEEF || d_rdata !== 32'h0) begin
      fails++;
      $display("FAIL store_issue: got %b addr %h wdata %h rdata %h expected 1101 00000100 deadbeef 0",
               {mem_req, mem_we, d_ready, d_stall}, mem_addr, mem_wdata, d_rdata);
    end
    next_cycle();
    mem_ready = 1'b1;
    #1;
    tests++;
    if ({d_ready, d_stall, if_ready} !== 3'b100 || d_rdata !== 32'h0) begin
      fails++;
      $display("FAIL store_done: got rdy/stall/if_rdy %b rdata %h expected 100 0",
               {d_ready, d_stall, if_ready}, d_rdata);
    end
    next_cycle();
    d_wr = 1'b0; mem_ready = 1'b0;
    #1;
    tests++;
    if (mem_req !== 1'b0 || mem_we !== 1'b0) begin
      fails++;
      $display("FAIL store_idle: got req %b we %b expected 0 0", mem_req, mem_we);
    end
  endtask

  task automatic test_simultaneous;
    if_req = 1'b1; if_addr = 32'h0000_0200;
    d_rd = 1'b1; d_addr = 32'h0000_0300;
    next_cycle();
    mem_ready = 1'b1; mem_rdata = 32'hAAAA_0001;
    #1;
    tests++;
    if (mem_addr !== 32'h300 || mem_we !== 1'b0 || d_ready !== 1'b1
        || d_rdata !== 32'hAAAA_0001 || if_ready !== 1'b0 || if_stall !== 1'b1) begin
      fails++;
      $display("FAIL simul_data_first: got addr %h we %b d_rdy %b d_rdata %h if_rdy %b if_stall %b",
               mem_addr, mem_we, d_ready, d_rdata, if_ready, if_stall);
    end
    next_cycle();
    d_rd = 1'b0; mem_ready = 1'b0; mem_rdata = '0;
    #1;
    tests++;
    if (mem_req !== 1'b0) begin
      fails++;
      $display("FAIL simul_gap: got mem_req %b expected 0", mem_req);
    end
    next_cycle();
    mem_ready = 1'b1; mem_rdata = 32'h5555_0002;
    #1;
    tests++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h200 || if_ready !== 1'b1
        || if_rdata !== 32'h5555_0002) begin
      fails++;
      $display("FAIL simul_fetch: got req %b addr %h rdy %b rdata %h expected 1 00000200 1 55550002",
               mem_req, mem_addr, if_ready, if_rdata);
    end
    next_cycle();
    if_req = 1'b0; mem_ready = 1'b0; mem_rdata = '0;
    next_cycle();
  endtask

  task automatic test_starvation;
    logic [31:0] got [10];
    logic [31:0] exp_addr;
    int n = 0;
    if_req = 1'b1; if_addr = 32'h0000_0080;
    d_rd = 1'b1; d_addr = 32'h0000_0400;
    for (int c = 0; c < 60 && n < 10; c++) begin
      next_cycle();
      mem_ready = mem_req;
      if (mem_req) begin
        got[n] = mem_addr;
        n++;
      end
    end
    tests++;
    if (n != 10) begin
      fails++;
      $display("FAIL starve_budget: got %0d grants expected 10", n);
    end
    for (int k = 0; k < n; k++) begin
      exp_addr = (k % 5 == 4) ? 32'h0000_0080 : 32'h0000_0400;
      tests++;
      if (got[k] !== exp_addr) begin
        fails++;
        $display("FAIL starve_grant%0d: got addr %h expected %h", k, got[k], exp_addr);
      end
    end
    next_cycle();
    mem_ready = 1'b0; if_req = 1'b0; d_rd = 1'b0;
    next_cycle();
  endtask

  task automatic test_abandoned;
    if_req = 1'b1; if_addr = 32'h0000_00C0;
    next_cycle();
    if_req = 1'b0;
    next_cycle();
    mem_ready = 1'b1; mem_rdata = 32'h0000_0077;
    #1;
    tests++;
    if (if_ready !== 1'b1 || if_rdata !== 32'h77 || if_stall !== 1'b0 || mem_addr !== 32'hC0) begin
      fails++;
      $display("FAIL abandon_done: got rdy %b rdata %h stall %b addr %h expected 1 00000077 0 000000c0",
               if_ready, if_rdata, if_stall, mem_addr);
    end
    next_cycle();
    d_rd = 1'b1; d_wr = 1'b1; d_addr = 32'h0000_0500; d_wdata = 32'h1234_5678;
    #1;
    tests++;
    if ({mem_req, if_ready, d_ready, d_stall} !== 4'b0001) begin
      fails++;
      $display("FAIL idle_ready_ignored: got req/if_rdy/d_rdy/d_stall %b expected 0001",
               {mem_req, if_ready, d_ready, d_stall});
    end
    next_cycle();
    mem_ready = 1'b0;
    #1;
    tests++;
    if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h500
        || mem_wdata !== 32'h1234_5678) begin
      fails++;
      $display("FAIL rdwr_as_write: got req %b we %b addr %h wdata %h expected 1 1 00000500 12345678",
               mem_req, mem_we, mem_addr, mem_wdata);
    end
    next_cycle();
    mem_ready = 1'b1;
    #1;
    tests++;
    if (d_ready !== 1'b1 || d_stall !== 1'b0) begin
      fails++;
      $display("FAIL rdwr_done: got rdy %b stall %b expected 1 0", d_ready, d_stall);
    end
    next_cycle();
    d_rd = 1'b0; d_wr = 1'b0; mem_ready = 1'b0;
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_store();
    test_simultaneous();
    test_starvation();
    test_abandoned();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
